// File: rtl/enemy_shot_ctrl_if.sv
// Fire-request handshake and projectile slot view shared by the engine, enemy_shot_ctrl and the renderer.
// Handshake: fire_req is a one-cycle strobe with no ready; exactly one of fire_ack/fire_drop pulses on the following edge.
interface enemy_shot_ctrl_if #(
    parameter int N_SHOTS = 4
);
    logic                    fire_req;
    logic [5:0]              shoot_id;
    logic [5:0]              shoot_row;
    logic                    fire_ack;
    logic                    fire_drop;
    logic [N_SHOTS-1:0]      shot_valid;
    logic [10*N_SHOTS-1:0]   shot_x;
    logic [10*N_SHOTS-1:0]   shot_y;

    modport master (
        output fire_req, shoot_id, shoot_row,
        input  fire_ack, fire_drop, shot_valid, shot_x, shot_y
    );

    modport slave (
        input  fire_req, shoot_id, shoot_row,
        output fire_ack, fire_drop, shot_valid, shot_x, shot_y
    );
endinterface

// File: rtl/enemy_shot_ctrl.sv
// Enemy projectile spawner/mover with player hit detection.
// Optional macro ENEMY_SHOT_LIVES_EN: 3-life counter instead of one-hit death.
module enemy_shot_ctrl #(
    parameter int COLUNAS   = 13,
    parameter int LINHAS    = 5,
    parameter int N_SHOTS   = 4,
    parameter int MOVE_DIV  = 500000,
    parameter int SHOT_STEP = 4,
    parameter int SCREEN_H  = 480,
    parameter int ENEMY_DX  = 32,
    parameter int ENEMY_DY  = 24,
    parameter int ENEMY_W   = 24,
    parameter int ENEMY_H   = 16,
    parameter int PLAYER_W  = 32,
    parameter int PLAYER_H  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        restart,
    enemy_shot_ctrl_if.slave            bus,
    input  logic [COLUNAS*LINHAS-1:0]   enemy_vivos,
    input  logic [9:0]                  fleet_x,
    input  logic [9:0]                  fleet_y,
    input  logic [9:0]                  player_x,
    input  logic [9:0]                  player_y,
    output logic                        player_hit,
    output logic                        jogador_vivo
);
    localparam int NUM_EN = COLUNAS * LINHAS;
    localparam int CW     = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N_SHOTS-1:0] valid_q, valid_d;
    logic [9:0]         x_q [N_SHOTS];
    logic [9:0]         x_d [N_SHOTS];
    logic [9:0]         y_q [N_SHOTS];
    logic [9:0]         y_d [N_SHOTS];
    logic               ack_q, ack_d;
    logic               drop_q, drop_d;
    logic               hit_q, hit_d;
    logic               vivo_q, vivo_d;
`ifdef ENEMY_SHOT_LIVES_EN
    logic [1:0]         lives_q, lives_d;
`endif

    logic               tick;
    logic [9:0]         col_w, spawn_x, spawn_y;
    logic               id_in_range, alive_bit, free_found, accept, hit_any;
    int                 free_idx;
    logic [10:0]        sum_y;
    logic [11:0]        sx, sy, px, py;

    assign tick = (cnt_q == CW'(MOVE_DIV - 1));

    // Spawn point sits centred under the shooter, at its bottom edge.
    assign col_w   = 10'(bus.shoot_id) - 10'(bus.shoot_row) * 10'(COLUNAS);
    assign spawn_x = col_w * 10'(ENEMY_DX) + 10'(ENEMY_W / 2) + fleet_x;
    assign spawn_y = 10'(bus.shoot_row) * 10'(ENEMY_DY) + 10'(ENEMY_H) + fleet_y;

    assign id_in_range = ({26'd0, bus.shoot_id} < 32'(NUM_EN));
    assign alive_bit   = |(enemy_vivos & (NUM_EN'(1) << bus.shoot_id));

    always_comb begin
        free_found = 1'b0;
        free_idx   = 0;
        for (int i = N_SHOTS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = i;
            end
        end
    end

    assign accept = bus.fire_req && id_in_range && alive_bit && vivo_q && free_found;

    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + CW'(1);
        valid_d = valid_q;
        x_d     = x_q;
        y_d     = y_q;
        ack_d   = 1'b0;
        drop_d  = 1'b0;
        hit_d   = 1'b0;
        vivo_d  = vivo_q;
        hit_any = 1'b0;
        sum_y   = '0;
        sx      = '0;
        sy      = '0;
        px      = {2'b00, player_x};
        py      = {2'b00, player_y};
`ifdef ENEMY_SHOT_LIVES_EN
        lives_d = lives_q;
`endif

        if (tick) begin
            for (int i = 0; i < N_SHOTS; i++) begin
                if (valid_q[i]) begin
                    sum_y = {1'b0, y_q[i]} + 11'(SHOT_STEP);
                    sx    = {2'b00, x_q[i]};
                    sy    = {1'b0, sum_y};
                    if (sum_y >= 11'(SCREEN_H)) begin
                        valid_d[i] = 1'b0;
                    end else begin
                        y_d[i] = sum_y[9:0];
                        // 2x6 shot box against the player box, on the moved position.
                        if (vivo_q && (sx < px + 12'(PLAYER_W)) && (sx + 12'd2 > px) &&
                            (sy < py + 12'(PLAYER_H)) && (sy + 12'd6 > py)) begin
                            valid_d[i] = 1'b0;
                            hit_any    = 1'b1;
                        end
                    end
                end
            end
        end

        // Free slot is taken from pre-tick occupancy, so a slot retired this tick stays busy.
        if (bus.fire_req) begin
            if (accept) begin
                ack_d = 1'b1;
                for (int i = 0; i < N_SHOTS; i++) begin
                    if (i == free_idx) begin
                        valid_d[i] = 1'b1;
                        x_d[i]     = spawn_x;
                        y_d[i]     = spawn_y;
                    end
                end
            end else begin
                drop_d = 1'b1;
            end
        end

        if (hit_any) begin
            hit_d = 1'b1;
`ifdef ENEMY_SHOT_LIVES_EN
            lives_d = lives_q - 2'd1;
            vivo_d  = (lives_d != 2'd0);
`else
            vivo_d  = 1'b0;
`endif
        end

        if (restart) begin
            cnt_d   = '0;
            valid_d = '0;
            for (int i = 0; i < N_SHOTS; i++) begin
                x_d[i] = '0;
                y_d[i] = '0;
            end
            ack_d  = 1'b0;
            drop_d = 1'b0;
            hit_d  = 1'b0;
            vivo_d = 1'b1;
`ifdef ENEMY_SHOT_LIVES_EN
            lives_d = 2'd3;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            valid_q <= '0;
            for (int i = 0; i < N_SHOTS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            ack_q  <= 1'b0;
            drop_q <= 1'b0;
            hit_q  <= 1'b0;
            vivo_q <= 1'b1;
`ifdef ENEMY_SHOT_LIVES_EN
            lives_q <= 2'd3;
`endif
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ack_q   <= ack_d;
            drop_q  <= drop_d;
            hit_q   <= hit_d;
            vivo_q  <= vivo_d;
`ifdef ENEMY_SHOT_LIVES_EN
            lives_q <= lives_d;
`endif
        end
    end

    assign bus.fire_ack   = ack_q;
    assign bus.fire_drop  = drop_q;
    assign bus.shot_valid = valid_q;
    assign player_hit     = hit_q;
    assign jogador_vivo   = vivo_q;

    for (genvar g = 0; g < N_SHOTS; g++) begin : g_pack
        assign bus.shot_x[10*g +: 10] = x_q[g];
        assign bus.shot_y[10*g +: 10] = y_q[g];
    end
endmodule

// File: tb/tb_enemy_shot_ctrl.sv
// Directed bench for enemy_shot_ctrl; movement divider shortened to 16 cycles.
// Define ENEMY_SHOT_LIVES_EN for both bench and RTL to exercise the life counter.
module tb_enemy_shot_ctrl;
    localparam int MOVE_DIV = 16;
    localparam int N_SHOTS  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        restart;
    logic [64:0] enemy_vivos;
    logic [9:0]  fleet_x, fleet_y, player_x, player_y;
    logic        player_hit, jogador_vivo;

    int checks   = 0;
    int failures = 0;
    int cnt_m    = 0;

    enemy_shot_ctrl_if #(.N_SHOTS(N_SHOTS)) bus();

    enemy_shot_ctrl #(.N_SHOTS(N_SHOTS), .MOVE_DIV(MOVE_DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .restart      (restart),
        .bus          (bus.slave),
        .enemy_vivos  (enemy_vivos),
        .fleet_x      (fleet_x),
        .fleet_y      (fleet_y),
        .player_x     (player_x),
        .player_y     (player_y),
        .player_hit   (player_hit),
        .jogador_vivo (jogador_vivo)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // One clock; cnt_m tracks the tick divider (tick acts on the edge where it wraps).
    task automatic step();
        bit tk, rs;
        tk = (cnt_m == MOVE_DIV - 1);
        rs = restart;
        @(posedge clk);
        #1;
        if (rs || tk) cnt_m = 0;
        else          cnt_m++;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    task automatic fire(input int id, input int row);
        bus.fire_req  = 1'b1;
        bus.shoot_id  = 6'(id);
        bus.shoot_row = 6'(row);
        step();
        bus.fire_req  = 1'b0;
    endtask

    // Advance until the next edge is a tick edge.
    task automatic wait_pre_tick();
        int n = 0;
        while (cnt_m != MOVE_DIV - 1 && n < MOVE_DIV + 2) begin
            step();
            n++;
        end
    endtask

    task automatic summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        summary();
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        reset         = 1'b0;
        restart       = 1'b0;
        bus.fire_req  = 1'b0;
        bus.shoot_id  = '0;
        bus.shoot_row = '0;
        enemy_vivos   = '1;
        enemy_vivos[20] = 1'b0;
        fleet_x  = 10'd0;
        fleet_y  = 10'd0;
        player_x = 10'd900;
        player_y = 10'd300;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", 64'(bus.shot_valid), 0);
        check_eq("rst_shot_x", 64'(bus.shot_x), 0);
        check_eq("rst_shot_y", 64'(bus.shot_y), 0);
        check_eq("rst_vivo", 64'(jogador_vivo), 1);
        check_eq("rst_ack", 64'(bus.fire_ack), 0);
        check_eq("rst_drop", 64'(bus.fire_drop), 0);
        check_eq("rst_hit", 64'(player_hit), 0);
        reset = 1'b1;
        cnt_m = 0;

        // Single spawn: id 14 = row 1 col 1 -> (44,40)
        fire(14, 1);
        check_eq("t1_ack", 64'(bus.fire_ack), 1);
        check_eq("t1_drop", 64'(bus.fire_drop), 0);
        check_eq("t1_valid", 64'(bus.shot_valid), 4'b0001);
        check_eq("t1_x0", 64'(bus.shot_x[9:0]), 44);
        check_eq("t1_y0", 64'(bus.shot_y[9:0]), 40);
        step();
        check_eq("t1_ack_pulse", 64'(bus.fire_ack), 0);

        // Five requests, four slots
        do_restart();
        check_eq("t2_restart_valid", 64'(bus.shot_valid), 0);
        fire(0, 0);
        check_eq("t2_ack0", 64'(bus.fire_ack), 1);
        check_eq("t2_v0", 64'(bus.shot_valid), 4'b0001);
        fire(14, 1);
        check_eq("t2_v1", 64'(bus.shot_valid), 4'b0011);
        fire(27, 2);
        check_eq("t2_v2", 64'(bus.shot_valid), 4'b0111);
        check_eq("t2_x2", 64'(bus.shot_x[29:20]), 44);
        check_eq("t2_y2", 64'(bus.shot_y[29:20]), 64);
        fire(40, 3);
        check_eq("t2_ack3", 64'(bus.fire_ack), 1);
        check_eq("t2_v3", 64'(bus.shot_valid), 4'b1111);
        check_eq("t2_y3", 64'(bus.shot_y[39:30]), 88);
        fire(50, 3);
        check_eq("t2_drop5", 64'(bus.fire_drop), 1);
        check_eq("t2_ack5", 64'(bus.fire_ack), 0);
        check_eq("t2_v5", 64'(bus.shot_valid), 4'b1111);

        // Dead shooter
        do_restart();
        fire(14, 1);
        fire(20, 1);
        check_eq("t3_drop", 64'(bus.fire_drop), 1);
        check_eq("t3_ack", 64'(bus.fire_ack), 0);
        check_eq("t3_valid", 64'(bus.shot_valid), 4'b0001);

        // Retire at screen bottom, fire on the same tick edge
        do_restart();
        fleet_y = 10'd460;
        fire(0, 0);
        check_eq("t4_y0", 64'(bus.shot_y[9:0]), 476);
        wait_pre_tick();
        fire(1, 0);
        check_eq("t4_ack", 64'(bus.fire_ack), 1);
        check_eq("t4_valid", 64'(bus.shot_valid), 4'b0010);
        check_eq("t4_x1", 64'(bus.shot_x[19:10]), 44);
        check_eq("t4_y1", 64'(bus.shot_y[19:10]), 476);
        check_eq("t4_nohit", 64'(player_hit), 0);
        wait_pre_tick();
        step();
        check_eq("t4_retire", 64'(bus.shot_valid), 0);
        check_eq("t4_nohit2", 64'(player_hit), 0);

        // Two shots hit together, third misses
        do_restart();
        fleet_y  = 10'd0;
        player_x = 10'd13;
        player_y = 10'd18;
        fire(0, 0);
        fire(1, 0);
        fire(2, 0);
        check_eq("t5_pre", 64'(bus.shot_valid), 4'b0111);
        wait_pre_tick();
        step();
        check_eq("t5_valid", 64'(bus.shot_valid), 4'b0100);
        check_eq("t5_hit", 64'(player_hit), 1);
        check_eq("t5_y2", 64'(bus.shot_y[29:20]), 20);
`ifdef ENEMY_SHOT_LIVES_EN
        check_eq("t6_vivo1", 64'(jogador_vivo), 1);
        step();
        check_eq("t5_hit_pulse", 64'(player_hit), 0);
        fire(0, 0);
        wait_pre_tick();
        step();
        check_eq("t6_hit2", 64'(player_hit), 1);
        check_eq("t6_vivo2", 64'(jogador_vivo), 1);
        fire(0, 0);
        check_eq("t6_ack3", 64'(bus.fire_ack), 1);
        wait_pre_tick();
        step();
        check_eq("t6_hit3", 64'(player_hit), 1);
        check_eq("t6_vivo3", 64'(jogador_vivo), 0);
`else
        check_eq("t5_vivo", 64'(jogador_vivo), 0);
        step();
        check_eq("t5_hit_pulse", 64'(player_hit), 0);
`endif
        fire(3, 0);
        check_eq("t5_dead_drop", 64'(bus.fire_drop), 1);
        check_eq("t5_dead_ack", 64'(bus.fire_ack), 0);
        do_restart();
        check_eq("t5_restart_vivo", 64'(jogador_vivo), 1);
        check_eq("t5_restart_valid", 64'(bus.shot_valid), 0);
        fire(3, 0);
        check_eq("t5_alive_ack", 64'(bus.fire_ack), 1);

        summary();
        $finish;
    end
endmodule
